// File: rtl/axi_llc_tag_res_router_pkg.sv
// Shared types for the LLC tag-store response router: configuration, descriptor,
// tag store response and the route a looked-up descriptor takes.
package axi_llc_tag_res_router_pkg;

   typedef struct packed {
      int unsigned SetAssociativity;
      int unsigned TagLength;
   } llc_cfg_t;

   localparam llc_cfg_t LlcCfg = '{SetAssociativity: 32'd4, TagLength: 32'd12};
   localparam int unsigned NumWays = LlcCfg.SetAssociativity;
   localparam int unsigned TagW    = LlcCfg.TagLength;

   typedef logic [NumWays-1:0] way_ind_t;
   typedef logic [TagW-1:0]    tag_t;

   typedef struct packed {
      way_ind_t way_ind;
      logic     evict;
      tag_t     evict_tag;
      logic     refill;
      logic     flush;
      logic     rw;
   } desc_t;

   typedef struct packed {
      way_ind_t indicator;
      logic     hit;
      logic     evict;
      tag_t     evict_tag;
   } store_res_t;

   typedef enum logic [1:0] {RouteHit, RouteEvict, RouteRefill, RouteDrop} route_e;

   // Flushes only care about dirtiness; normal lookups split on hit, then dirtiness.
   function automatic route_e route_of(input logic flush, input logic hit, input logic evict);
      if (flush) return evict ? RouteEvict : RouteDrop;
      if (hit)   return RouteHit;
      return evict ? RouteEvict : RouteRefill;
   endfunction

endpackage

// File: rtl/axi_llc_tag_res_router_if.sv
// Handshake bundle around the router: descriptor in, tag response in, three routed outputs.
interface axi_llc_tag_res_router_if;
   import axi_llc_tag_res_router_pkg::*;

   desc_t      desc;
   logic       desc_valid;
   logic       desc_ready;
   store_res_t res;
   logic       res_valid;
   logic       res_ready;
   desc_t      hit_desc;
   logic       hit_valid;
   logic       hit_ready;
   desc_t      evict_desc;
   logic       evict_valid;
   logic       evict_ready;
   desc_t      refill_desc;
   logic       refill_valid;
   logic       refill_ready;

   modport slave (
      input  desc, desc_valid, res, res_valid, hit_ready, evict_ready, refill_ready,
      output desc_ready, res_ready, hit_desc, hit_valid, evict_desc, evict_valid,
             refill_desc, refill_valid
   );

   modport master (
      output desc, desc_valid, res, res_valid, hit_ready, evict_ready, refill_ready,
      input  desc_ready, res_ready, hit_desc, hit_valid, evict_desc, evict_valid,
             refill_desc, refill_valid
   );

endinterface

// File: rtl/axi_llc_tag_res_router_fifo.sv
// Registered-output descriptor FIFO holding lookups that await their tag store response.
module axi_llc_tag_res_router_fifo
   import axi_llc_tag_res_router_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  push_i,
   input  desc_t data_i,
   input  logic  pop_i,
   output desc_t data_o,
   output logic  empty_o,
   output logic  full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            push, pop;
   desc_t           mem_q [Depth];

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign data_o  = mem_q[rptr_q];

   always_comb begin
      push   = push_i & ~full_o;
      pop    = pop_i & ~empty_o;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      if (pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/axi_llc_tag_res_router.sv
// Joins in-order tag store responses with their queued descriptors, stamps the lookup
// result and routes to hit/evict/refill, throttling outstanding misses with credits.
module axi_llc_tag_res_router
   import axi_llc_tag_res_router_pkg::*;
#(
   parameter int unsigned MaxMiss   = 8,
   parameter int unsigned DescDepth = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   axi_llc_tag_res_router_if.slave        bus,
   input  logic                           miss_done_i,
   output logic                           flush_done_o,
   output logic [$clog2(MaxMiss+1)-1:0]   miss_cnt_o
);

   localparam int unsigned MissCntW = $clog2(MaxMiss + 1);

   desc_t                head, stamped, desc_q, desc_d;
   route_e               route;
   logic                 q_empty, q_full;
   logic                 is_miss, miss_dec, credit_ok, sel_ready, out_free, accept;
   logic [2:0]           valid_q, valid_d;
   logic                 flush_done_q, flush_done_d;
   logic [MissCntW-1:0]  miss_cnt_q, miss_cnt_d;

   axi_llc_tag_res_router_fifo #(.Depth(DescDepth)) i_desc_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (bus.desc_valid),
      .data_i  (bus.desc),
      .pop_i   (accept),
      .data_o  (head),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   // Join, route decode and output stage; valid_q is one-hot {refill, evict, hit}.
   always_comb begin
      route             = route_of(head.flush, bus.res.hit, bus.res.evict);
      is_miss           = ~head.flush & ~bus.res.hit;
      stamped           = head;
      stamped.way_ind   = bus.res.indicator;
      stamped.evict     = bus.res.evict;
      stamped.evict_tag = bus.res.evict_tag;
      stamped.refill    = is_miss;

      sel_ready = |(valid_q & {bus.refill_ready, bus.evict_ready, bus.hit_ready});
      out_free  = ~(|valid_q) | sel_ready;
      miss_dec  = miss_done_i & (miss_cnt_q != '0);
      // A completing refill frees its credit in time for a stalled miss this cycle.
      credit_ok = ~is_miss | (miss_cnt_q < MissCntW'(MaxMiss)) | miss_dec;
      accept    = bus.res_valid & ~q_empty & out_free & credit_ok;

      valid_d      = sel_ready ? 3'b000 : valid_q;
      desc_d       = desc_q;
      flush_done_d = 1'b0;
      miss_cnt_d   = miss_cnt_q;

      if (accept) begin
         unique case (route)
            RouteHit:    valid_d = 3'b001;
            RouteEvict:  valid_d = 3'b010;
            RouteRefill: valid_d = 3'b100;
            RouteDrop:   flush_done_d = 1'b1;
         endcase
         if (route != RouteDrop) desc_d = stamped;
      end

      if ((accept & is_miss) & ~miss_dec)      miss_cnt_d = miss_cnt_q + MissCntW'(1);
      else if (~(accept & is_miss) & miss_dec) miss_cnt_d = miss_cnt_q - MissCntW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q      <= 3'b000;
         desc_q       <= '0;
         flush_done_q <= 1'b0;
         miss_cnt_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         desc_q       <= desc_d;
         flush_done_q <= flush_done_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign bus.desc_ready   = ~q_full;
   assign bus.res_ready    = accept;
   assign bus.hit_desc     = desc_q;
   assign bus.evict_desc   = desc_q;
   assign bus.refill_desc  = desc_q;
   assign bus.hit_valid    = valid_q[0];
   assign bus.evict_valid  = valid_q[1];
   assign bus.refill_valid = valid_q[2];
   assign flush_done_o     = flush_done_q;
   assign miss_cnt_o       = miss_cnt_q;

   res_without_desc: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.res_valid && q_empty))
      else $error("tag store response with no queued descriptor");

   miss_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(miss_done_i && miss_cnt_q == '0))
      else $error("miss_done_i with no outstanding miss");

endmodule

// File: tb/tb_axi_llc_tag_res_router.sv
// Bench for the tag response router: directed scenarios plus a randomized run
// against a transaction-level model of queue, output slot and miss credits.
module tb_axi_llc_tag_res_router;
   import axi_llc_tag_res_router_pkg::*;

   localparam int unsigned MaxMiss   = 2;
   localparam int unsigned DescDepth = 2;
   localparam int R_HIT = 0, R_EVICT = 1, R_REFILL = 2, R_DROP = 3;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       miss_done_i;
   logic       flush_done_o;
   logic [1:0] miss_cnt_o;
   int         n_checks = 0;
   int         n_pass   = 0;

   axi_llc_tag_res_router_if bus ();

   axi_llc_tag_res_router #(.MaxMiss(MaxMiss), .DescDepth(DescDepth)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .miss_done_i  (miss_done_i),
      .flush_done_o (flush_done_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.desc_valid   = 1'b0;
      bus.desc         = '0;
      bus.res_valid    = 1'b0;
      bus.res          = '0;
      bus.hit_ready    = 1'b1;
      bus.evict_ready  = 1'b1;
      bus.refill_ready = 1'b1;
      miss_done_i      = 1'b0;
   endtask

   function automatic desc_t rand_desc(input bit flush);
      desc_t d;
      d.way_ind   = 4'($urandom);
      d.evict     = 1'($urandom);
      d.evict_tag = TagW'($urandom);
      d.refill    = 1'($urandom);
      d.flush     = flush;
      d.rw        = 1'($urandom);
      return d;
   endfunction

   function automatic store_res_t rand_res();
      store_res_t r;
      r.indicator = 4'(1 << $urandom_range(3));
      r.hit       = 1'($urandom);
      r.evict     = 1'($urandom);
      r.evict_tag = TagW'($urandom);
      return r;
   endfunction

   // Expected descriptor after the lookup result is written into it.
   function automatic desc_t stamp(input desc_t d, input store_res_t r);
      desc_t e = d;
      e.way_ind   = r.indicator;
      e.evict     = r.evict;
      e.evict_tag = r.evict_tag;
      e.refill    = !r.hit && !d.flush;
      return e;
   endfunction

   function automatic store_res_t mk_res(input logic [3:0] ind, input bit hit, input bit ev,
                                         input logic [11:0] tag);
      store_res_t r;
      r.indicator = ind;
      r.hit       = hit;
      r.evict     = ev;
      r.evict_tag = tag;
      return r;
   endfunction

   task automatic push_desc(input desc_t d);
      bus.desc       = d;
      bus.desc_valid = 1'b1;
      tick();
      bus.desc_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      repeat (3) tick();
      n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== 3'b000) $display("FAIL reset_valids got=%b exp=000", {bus.refill_valid, bus.evict_valid, bus.hit_valid}); else n_pass++;
      n_checks++; if (flush_done_o !== 1'b0) $display("FAIL reset_flush_done got=%b exp=0", flush_done_o); else n_pass++;
      n_checks++; if (miss_cnt_o !== 2'd0) $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt_o); else n_pass++;
      n_checks++; if (bus.desc_ready !== 1'b1) $display("FAIL reset_desc_ready got=%b exp=1", bus.desc_ready); else n_pass++;
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_hit();
      desc_t d = rand_desc(1'b0);
      store_res_t r = mk_res(4'b0010, 1'b1, 1'b0, 12'($urandom));
      d.rw = 1'b0;
      push_desc(d);
      bus.res = r; bus.res_valid = 1'b1;
      #1;
      n_checks++; if (bus.res_ready !== 1'b1) $display("FAIL hit_res_ready got=%b exp=1", bus.res_ready); else n_pass++;
      tick();
      bus.res_valid = 1'b0;
      n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== 3'b001) $display("FAIL hit_valids got=%b exp=001", {bus.refill_valid, bus.evict_valid, bus.hit_valid}); else n_pass++;
      n_checks++; if (bus.hit_desc !== stamp(d, r)) $display("FAIL hit_desc got=%h exp=%h", bus.hit_desc, stamp(d, r)); else n_pass++;
      n_checks++; if (bus.hit_desc.way_ind !== 4'b0010 || bus.hit_desc.refill !== 1'b0) $display("FAIL hit_way_refill got=%b/%b exp=0010/0", bus.hit_desc.way_ind, bus.hit_desc.refill); else n_pass++;
      tick();
      n_checks++; if (bus.hit_valid !== 1'b0) $display("FAIL hit_drained got=%b exp=0", bus.hit_valid); else n_pass++;
   endtask

   task automatic test_miss(input bit dirty);
      desc_t d = rand_desc(1'b0);
      store_res_t r = mk_res(4'b0100, 1'b0, dirty, dirty ? 12'h1A5 : 12'($urandom));
      logic [2:0] exp_v = dirty ? 3'b010 : 3'b100;
      desc_t got;
      push_desc(d);
      bus.res = r; bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      got = dirty ? bus.evict_desc : bus.refill_desc;
      n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== exp_v) $display("FAIL miss_valids dirty=%0d got=%b exp=%b", dirty, {bus.refill_valid, bus.evict_valid, bus.hit_valid}, exp_v); else n_pass++;
      n_checks++; if (got !== stamp(d, r)) $display("FAIL miss_desc dirty=%0d got=%h exp=%h", dirty, got, stamp(d, r)); else n_pass++;
      n_checks++; if (got.refill !== 1'b1 || (dirty && got.evict_tag !== 12'h1A5)) $display("FAIL miss_fields dirty=%0d got refill=%b tag=%h", dirty, got.refill, got.evict_tag); else n_pass++;
      n_checks++; if (miss_cnt_o !== 2'd1) $display("FAIL miss_cnt_inc got=%0d exp=1", miss_cnt_o); else n_pass++;
      miss_done_i = 1'b1;
      tick();
      miss_done_i = 1'b0;
      n_checks++; if (miss_cnt_o !== 2'd0) $display("FAIL miss_cnt_dec got=%0d exp=0", miss_cnt_o); else n_pass++;
   endtask

   task automatic test_credit_exhaust();
      desc_t d[3];
      store_res_t r[3];
      for (int i = 0; i < 3; i++) begin
         d[i] = rand_desc(1'b0);
         r[i] = mk_res(4'(1 << i), 1'b0, 1'b0, 12'($urandom));
      end
      push_desc(d[0]);
      push_desc(d[1]);
      n_checks++; if (bus.desc_ready !== 1'b0) $display("FAIL credit_queue_full got=%b exp=0", bus.desc_ready); else n_pass++;
      bus.res = r[0]; bus.res_valid = 1'b1;
      tick();
      bus.desc = d[2]; bus.desc_valid = 1'b1; bus.res = r[1];
      #1;
      n_checks++; if (bus.res_ready !== 1'b1) $display("FAIL credit_second_accept got=%b exp=1", bus.res_ready); else n_pass++;
      tick();
      bus.desc_valid = 1'b0; bus.res = r[2];
      #1;
      n_checks++; if (miss_cnt_o !== 2'd2) $display("FAIL credit_cnt_full got=%0d exp=2", miss_cnt_o); else n_pass++;
      n_checks++; if (bus.res_ready !== 1'b0) $display("FAIL credit_third_stall got=%b exp=0", bus.res_ready); else n_pass++;
      tick();
      n_checks++; if (bus.res_ready !== 1'b0) $display("FAIL credit_still_stall got=%b exp=0", bus.res_ready); else n_pass++;
      miss_done_i = 1'b1;
      #1;
      n_checks++; if (bus.res_ready !== 1'b1) $display("FAIL credit_accept_on_done got=%b exp=1", bus.res_ready); else n_pass++;
      tick();
      miss_done_i = 1'b0; bus.res_valid = 1'b0;
      n_checks++; if (miss_cnt_o !== 2'd2) $display("FAIL credit_cnt_hold got=%0d exp=2", miss_cnt_o); else n_pass++;
      n_checks++; if (bus.refill_valid !== 1'b1 || bus.refill_desc !== stamp(d[2], r[2])) $display("FAIL credit_third_out got=%b/%h exp=1/%h", bus.refill_valid, bus.refill_desc, stamp(d[2], r[2])); else n_pass++;
      miss_done_i = 1'b1;
      tick();
      tick();
      miss_done_i = 1'b0;
      n_checks++; if (miss_cnt_o !== 2'd0) $display("FAIL credit_cnt_drain got=%0d exp=0", miss_cnt_o); else n_pass++;
   endtask

   task automatic test_flush();
      desc_t d = rand_desc(1'b1);
      store_res_t r = mk_res(4'b1000, 1'($urandom), 1'b0, 12'($urandom));
      push_desc(d);
      bus.res = r; bus.res_valid = 1'b1;
      #1;
      n_checks++; if (bus.res_ready !== 1'b1) $display("FAIL flush_res_ready got=%b exp=1", bus.res_ready); else n_pass++;
      tick();
      bus.res_valid = 1'b0;
      n_checks++; if (flush_done_o !== 1'b1) $display("FAIL flush_done_pulse got=%b exp=1", flush_done_o); else n_pass++;
      n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== 3'b000) $display("FAIL flush_no_valid got=%b exp=000", {bus.refill_valid, bus.evict_valid, bus.hit_valid}); else n_pass++;
      tick();
      n_checks++; if (flush_done_o !== 1'b0) $display("FAIL flush_done_end got=%b exp=0", flush_done_o); else n_pass++;
      d = rand_desc(1'b1);
      r = mk_res(4'b0001, 1'($urandom), 1'b1, 12'($urandom));
      push_desc(d);
      bus.res = r; bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      n_checks++; if (bus.evict_valid !== 1'b1 || bus.evict_desc !== stamp(d, r)) $display("FAIL flush_evict got=%b/%h exp=1/%h", bus.evict_valid, bus.evict_desc, stamp(d, r)); else n_pass++;
      n_checks++; if (miss_cnt_o !== 2'd0 || flush_done_o !== 1'b0) $display("FAIL flush_evict_cnt got=%0d/%b exp=0/0", miss_cnt_o, flush_done_o); else n_pass++;
      tick();
   endtask

   task automatic test_backpressure_reset();
      desc_t d1 = rand_desc(1'b0);
      store_res_t r1 = mk_res(4'b0010, 1'b1, 1'b0, 12'($urandom));
      push_desc(rand_desc(1'b0));
      bus.res = mk_res(4'b0001, 1'b0, 1'b0, 12'h0); bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      bus.hit_ready = 1'b0;
      push_desc(d1);
      bus.res = r1; bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      push_desc(rand_desc(1'b0));
      push_desc(rand_desc(1'b0));
      bus.res = mk_res(4'b0100, 1'b1, 1'b0, 12'h0); bus.res_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (bus.hit_valid !== 1'b1 || bus.hit_desc !== stamp(d1, r1)) $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", i, bus.hit_valid, bus.hit_desc, stamp(d1, r1)); else n_pass++;
         n_checks++; if (bus.res_ready !== 1'b0 || bus.desc_ready !== 1'b0) $display("FAIL bp_stall cyc=%0d got res_ready=%b desc_ready=%b exp=0/0", i, bus.res_ready, bus.desc_ready); else n_pass++;
         tick();
      end
      rst_ni = 1'b0;
      bus.res_valid = 1'b0;
      #1;
      n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== 3'b000) $display("FAIL rst_valids got=%b exp=000", {bus.refill_valid, bus.evict_valid, bus.hit_valid}); else n_pass++;
      n_checks++; if (miss_cnt_o !== 2'd0 || bus.desc_ready !== 1'b1) $display("FAIL rst_cnt_queue got=%0d/%b exp=0/1", miss_cnt_o, bus.desc_ready); else n_pass++;
      idle();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   // Transaction-level model: queued descriptors, one output slot, outstanding miss count.
   task automatic test_random(input int cycles);
      desc_t mq[$];
      bit    sv = 0;
      int    sr = 0;
      desc_t sd = '0;
      int    mcnt = 0;
      bit    efd = 0;
      for (int c = 0; c < cycles; c++) begin
         desc_t      nd, hd, got;
         store_res_t r;
         int         rt;
         bit         miss, drain, acc, push;
         logic [2:0] exp_v;
         nd = rand_desc($urandom_range(3) == 0);
         r  = rand_res();
         bus.desc         = nd;
         bus.desc_valid   = 1'($urandom);
         bus.res          = r;
         bus.res_valid    = (mq.size() > 0) && ($urandom_range(2) != 0);
         bus.hit_ready    = ($urandom_range(3) != 0);
         bus.evict_ready  = ($urandom_range(3) != 0);
         bus.refill_ready = ($urandom_range(3) != 0);
         miss_done_i      = (mcnt > 0) && ($urandom_range(3) == 0);
         #1;
         hd = '0;
         if (mq.size() > 0) hd = mq[0];
         miss = !hd.flush && !r.hit;
         if (hd.flush) rt = r.evict ? R_EVICT : R_DROP;
         else if (miss) rt = r.evict ? R_EVICT : R_REFILL;
         else rt = R_HIT;
         drain = sv && ((sr == R_HIT && bus.hit_ready) || (sr == R_EVICT && bus.evict_ready) ||
                        (sr == R_REFILL && bus.refill_ready));
         acc = bus.res_valid && (mq.size() > 0) && (!sv || drain) &&
               (!miss || mcnt < MaxMiss || miss_done_i);
         exp_v = sv ? 3'(1 << sr) : 3'b000;
         got = (sr == R_HIT) ? bus.hit_desc : (sr == R_EVICT) ? bus.evict_desc : bus.refill_desc;
         n_checks++; if (bus.res_ready !== acc) $display("FAIL rnd_res_ready cyc=%0d got=%b exp=%b", c, bus.res_ready, acc); else n_pass++;
         n_checks++; if (bus.desc_ready !== (mq.size() < DescDepth)) $display("FAIL rnd_desc_ready cyc=%0d got=%b exp=%b", c, bus.desc_ready, mq.size() < DescDepth); else n_pass++;
         n_checks++; if ({bus.refill_valid, bus.evict_valid, bus.hit_valid} !== exp_v) $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", c, {bus.refill_valid, bus.evict_valid, bus.hit_valid}, exp_v); else n_pass++;
         if (sv) begin
            n_checks++; if (got !== sd) $display("FAIL rnd_desc cyc=%0d got=%h exp=%h", c, got, sd); else n_pass++;
         end
         n_checks++; if (flush_done_o !== efd) $display("FAIL rnd_flush_done cyc=%0d got=%b exp=%b", c, flush_done_o, efd); else n_pass++;
         n_checks++; if (int'(miss_cnt_o) != mcnt) $display("FAIL rnd_miss_cnt cyc=%0d got=%0d exp=%0d", c, miss_cnt_o, mcnt); else n_pass++;
         push = bus.desc_valid && (mq.size() < DescDepth);
         efd  = acc && (rt == R_DROP);
         if (acc) begin
            void'(mq.pop_front());
            sv = (rt != R_DROP);
            sr = rt;
            sd = stamp(hd, r);
         end else if (drain) begin
            sv = 0;
         end
         mcnt = mcnt + int'(acc && miss) - int'(miss_done_i);
         if (push) mq.push_back(nd);
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss(1'b0);
      test_miss(1'b1);
      test_credit_exhaust();
      test_flush();
      test_backpressure_reset();
      test_random(400);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
